// File: rtl/fetch_mem_port_if.sv
// Bundles the fetch-stage request/response bus and the backing-RAM read bus of fetch_mem_port.
// Widths come from DATA_WIDTH / FETCH_ID_SIZE (globals), with local fallbacks.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef FETCH_ID_SIZE
`define FETCH_ID_SIZE 4
`endif

interface fetch_mem_port_if;
  logic [`DATA_WIDTH-1:0]    fetch_addr;
  logic [`FETCH_ID_SIZE-1:0] fetch_id;
  logic                      fetch_valid;
  logic                      fetch_flush;
  logic                      mem_stall;
  logic [`DATA_WIDTH-1:0]    mem_data;
  logic [`FETCH_ID_SIZE-1:0] mem_id;
  logic                      mem_valid;
  logic                      ram_req;
  logic [`DATA_WIDTH-1:0]    ram_addr;
  logic                      ram_ack;
  logic [`DATA_WIDTH-1:0]    ram_rdata;

  modport master (
    output fetch_addr, fetch_id, fetch_valid, fetch_flush, ram_ack, ram_rdata,
    input  mem_stall, mem_data, mem_id, mem_valid, ram_req, ram_addr
  );

  modport slave (
    input  fetch_addr, fetch_id, fetch_valid, fetch_flush, ram_ack, ram_rdata,
    output mem_stall, mem_data, mem_id, mem_valid, ram_req, ram_addr
  );
endinterface

// File: rtl/fetch_mem_port.sv
// Instruction-fetch memory port: in-order request queue in front of a single-outstanding RAM reader.
// Optional macro FETCH_LAST_HIT_EN adds a one-entry last-word buffer that answers repeat addresses.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef FETCH_ID_SIZE
`define FETCH_ID_SIZE 4
`endif

module fetch_mem_port #(
  parameter int QDEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  fetch_mem_port_if.slave bus
);

  localparam int DW    = `DATA_WIDTH;
  localparam int IW    = `FETCH_ID_SIZE;
  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic [DW-1:0]    q_addr [QDEPTH];
  logic [IW-1:0]    q_id   [QDEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [DW-1:0]    cur_addr;
  logic [IW-1:0]    cur_id;
  logic             drop;
  logic [DW-1:0]    mem_data_r;
  logic [IW-1:0]    mem_id_r;
  logic             mem_valid_r;

  logic             mem_stall;
  logic             accept, q_empty, load, pop, push, hit;
  logic [DW-1:0]    load_addr;
  logic [IW-1:0]    load_id;

`ifdef FETCH_LAST_HIT_EN
  logic [DW-1:0]    lh_addr;
  logic [DW-1:0]    lh_data;
  logic             lh_valid;
`endif

  assign mem_stall = (count == CNT_W'(QDEPTH));
  assign accept    = bus.fetch_valid && !mem_stall;
  assign q_empty   = (count == '0);

  // A flush discards the queue, so the head is never popped in that cycle;
  // an idle block with nothing usable queued loads an accepted fetch directly.
  always_comb begin
    load      = 1'b0;
    pop       = 1'b0;
    load_addr = bus.fetch_addr;
    load_id   = bus.fetch_id;
    if (state == IDLE) begin
      if (!bus.fetch_flush && !q_empty) begin
        load      = 1'b1;
        pop       = 1'b1;
        load_addr = q_addr[rd_ptr];
        load_id   = q_id[rd_ptr];
      end else if (accept) begin
        load = 1'b1;
      end
    end else if (state == RESP) begin
      if (!bus.fetch_flush && !q_empty) begin
        load      = 1'b1;
        pop       = 1'b1;
        load_addr = q_addr[rd_ptr];
        load_id   = q_id[rd_ptr];
      end
    end
  end

  assign push = accept && !(load && !pop);

`ifdef FETCH_LAST_HIT_EN
  assign hit = load && lh_valid && !bus.fetch_flush && (lh_addr == load_addr);
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= bus.fetch_addr;
      q_id[wr_ptr]   <= bus.fetch_id;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      cur_addr    <= '0;
      cur_id      <= '0;
      drop        <= 1'b0;
      mem_data_r  <= '0;
      mem_id_r    <= '0;
      mem_valid_r <= 1'b0;
`ifdef FETCH_LAST_HIT_EN
      lh_addr     <= '0;
      lh_data     <= '0;
      lh_valid    <= 1'b0;
`endif
    end else begin
      mem_valid_r <= 1'b0;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (bus.fetch_flush) begin
        rd_ptr <= wr_ptr;
        count  <= CNT_W'(push);
      end else begin
        rd_ptr <= rd_ptr + PTR_W'(pop);
        count  <= count + CNT_W'(push) - CNT_W'(pop);
      end

`ifdef FETCH_LAST_HIT_EN
      if (bus.fetch_flush) lh_valid <= 1'b0;
`endif

      case (state)
        IDLE, RESP: begin
          state <= IDLE;
          if (load) begin
            cur_addr <= load_addr;
            cur_id   <= load_id;
            if (hit) begin
              state       <= RESP;
              mem_valid_r <= 1'b1;
              mem_id_r    <= load_id;
`ifdef FETCH_LAST_HIT_EN
              mem_data_r  <= lh_data;
`endif
            end else begin
              state <= REQ;
            end
          end
        end
        REQ: begin
          // A flushed transaction still runs to its ack, which is then swallowed.
          if (bus.fetch_flush) drop <= 1'b1;
          if (bus.ram_ack) begin
            drop <= 1'b0;
            if (drop || bus.fetch_flush) begin
              state <= IDLE;
            end else begin
              state       <= RESP;
              mem_valid_r <= 1'b1;
              mem_data_r  <= bus.ram_rdata;
              mem_id_r    <= cur_id;
`ifdef FETCH_LAST_HIT_EN
              lh_addr     <= cur_addr;
              lh_data     <= bus.ram_rdata;
              lh_valid    <= 1'b1;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_stall = mem_stall;
  assign bus.mem_data  = mem_data_r;
  assign bus.mem_id    = mem_id_r;
  assign bus.mem_valid = mem_valid_r;
  assign bus.ram_req   = (state == REQ);
  assign bus.ram_addr  = cur_addr;

endmodule

// File: doc/fetch_mem_port.md
FETCH_MEM_PORT -- requirements
Module: fetch_mem_port

Interface
REQ-001 Parameter QDEPTH, default 4, SHALL be the request queue depth; it SHALL be a power of two, 2..16.
REQ-002 Data and address width SHALL be `DATA_WIDTH; ID width SHALL be `FETCH_ID_SIZE, both from globals.vh.
REQ-003 clk  in  1  clock; all state SHALL update on posedge clk.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 fetch_addr  in  DATA_WIDTH  instruction fetch address from the fetch stage.
REQ-006 fetch_id  in  FETCH_ID_SIZE  tag of the fetch request.
REQ-007 fetch_valid  in  1  fetch request strobe; accepted when mem_stall=0.
REQ-008 fetch_flush  in  1  discards all queued and in-flight requests.
REQ-009 mem_stall  out  1  queue full; new fetches are refused.
REQ-010 mem_data  out  DATA_WIDTH  returned instruction word.
REQ-011 mem_id  out  FETCH_ID_SIZE  tag of the returned word.
REQ-012 mem_valid  out  1  mem_data/mem_id valid; registered, one-cycle pulse per response.
REQ-013 ram_req  out  1  backing-RAM read request, held until ram_ack.
REQ-014 ram_addr  out  DATA_WIDTH  backing-RAM read address, stable while ram_req=1.
REQ-015 ram_ack  in  1  RAM read complete; ram_rdata valid in the same cycle.
REQ-016 ram_rdata  in  DATA_WIDTH  RAM read data.

Function
REQ-017 The FIFO SHALL hold {addr,id}; enqueue SHALL occur on fetch_valid=1 with mem_stall=0; mem_stall SHALL equal (count==QDEPTH) decoded from registered count.
REQ-018 fetch_valid while mem_stall=1 SHALL be ignored; no state change.
REQ-019 FSM states: IDLE, REQ, RESP.
REQ-020 IDLE: queue non-empty -> pop head into cur_addr/cur_id, go to REQ; queue empty with an accepted fetch -> bypass the queue, load it directly, go to REQ; otherwise stay.
REQ-021 REQ: ram_req=1 and ram_addr=cur_addr; on ram_ack, capture ram_rdata into mem_data, go to RESP.
REQ-022 RESP: mem_valid=1 for exactly one cycle; then pop head and go to REQ if the queue is non-empty, else go to IDLE.
REQ-023 Minimum latency: fetch_valid in cycle C into an empty idle block -> ram_req in C+1 -> zero-wait ack in C+1 -> mem_valid in C+2.
REQ-024 Responses SHALL return in request order, with mem_id equal to the request's fetch_id.
REQ-025 ram_ack outside REQ SHALL be ignored.
REQ-026 Dequeue and enqueue in the same cycle SHALL leave count unchanged; pointers SHALL wrap modulo QDEPTH.
REQ-027 fetch_flush SHALL empty the queue at the next edge.
REQ-028 A flush during REQ SHALL let the RAM transaction complete, then go to IDLE with no mem_valid.
REQ-029 A flush during RESP SHALL not alter that cycle's mem_valid pulse.
REQ-030 A fetch_valid in the flush cycle SHALL be accepted and kept.
REQ-031 mem_data and mem_id SHALL hold their last values while mem_valid=0.

Reset
REQ-032 Reset SHALL override all other inputs.
REQ-033 On reset: state=IDLE, queue empty, mem_stall=0, mem_valid=0, ram_req=0, ram_addr=0, mem_data=0, mem_id=0, drop flag cleared.
REQ-034 Reset mid-transaction SHALL abandon the RAM request (ram_req=0 next cycle) with no response.

Configuration
REQ-035 With macro FETCH_LAST_HIT_EN defined, a one-entry {addr,data,valid} last-word buffer SHALL exist. A pop whose address matches a valid entry SHALL go directly to RESP with the buffered data and no ram_req, saving one cycle. Each RAM completion SHALL update the buffer. Reset and fetch_flush SHALL invalidate it.
REQ-036 Without FETCH_LAST_HIT_EN, the buffer SHALL be absent and every request SHALL go through REQ.

Verification
REQ-037 Reset, then a single fetch addr=0x0 id=0 with RAM zero-wait ack data=0xDEADBEEF -> mem_valid in C+2 with mem_data=0xDEADBEEF, mem_id=0.
REQ-038 6 back-to-back fetches with RAM ack delayed 3 cycles, QDEPTH=4 -> mem_stall=1 once 4 are queued; all accepted ids return in order; no loss or duplicates.
REQ-039 fetch_flush while in REQ for id=2 with 2 queued -> RAM ack consumed, no mem_valid for ids 2..4, queue empty, mem_stall=0.
REQ-040 fetch_flush plus fetch_valid (addr=0x40, id=5) in the same cycle -> only id=5 returns afterwards.
REQ-041 Reset asserted during REQ -> ram_req=0 next cycle, no mem_valid, all outputs at reset values.
REQ-042 FETCH_LAST_HIT_EN defined, fetch addr=0x10 twice -> second response issues no ram_req and arrives one cycle earlier; without the macro, two RAM requests are issued.
